elbeth_fetch_sequencer: RTL and testbench

//  Sequences the program counter register and the instruction-memory fetch port.
//  - Computes next_pc and pc_stall for the PC register.
//  - Runs the imem req/ack handshake and buffers one fetched instruction for decode.
//  - Applies exception and branch/jump redirects, including one arriving mid-fetch.

---
 rtl/elbeth_fetch_sequencer.sv | 177 +++++++++++++++++
 tb/tb_elbeth_fetch_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_fetch_sequencer.sv
// Fetch sequencer: computes the PC register update, runs the imem req/ack
// handshake and holds one fetched instruction for decode.
module elbeth_fetch_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0010,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        fetch_err
);
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          pend;
    logic [31:0]   pend_target;
    logic [TW-1:0] tcount;

    logic          flush;
    logic [31:0]   flush_target;
    logic          blocked;
    logic          timeout_hit;
    logic          fill;
    logic          kill;
    logic          pend_set;
    logic          pend_clr;

    assign flush        = exc_valid | redirect_valid;
    assign flush_target = exc_valid ? EXC_VECTOR : redirect_pc;
    assign blocked      = inst_valid & id_stall;
    assign imem_addr    = pc;
    assign timeout_hit  = (TIMEOUT != 0) && (state == FETCH) && !imem_ack && !flush
                          && (tcount == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (timeout_hit) begin
                    state_nxt = ERR;
                end else if (imem_ack && !flush && !pend && blocked) begin
                    state_nxt = HOLD;
                end
            end
            HOLD:  if (!id_stall || flush) state_nxt = FETCH;
            ERR:   if (exc_valid) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs and buffer/pend controls
    always_comb begin
        pc_stall = 1'b1;
        next_pc  = pc;
        imem_req = 1'b0;
        fill     = 1'b0;
        kill     = 1'b0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pend_clr = 1'b1;
                    if (flush) begin
                        pc_stall = 1'b0;
                        next_pc  = flush_target;
                        kill     = 1'b1;
                    end else if (pend) begin
                        pc_stall = 1'b0;
                        next_pc  = pend_target;
                        kill     = 1'b1;
                    end else if (!blocked) begin
                        pc_stall = 1'b0;
                        next_pc  = pc + 32'd4;
                        fill     = 1'b1;
                    end
                end else if (flush) begin
                    // The outstanding request cannot be withdrawn; redirect on its ack.
                    kill     = 1'b1;
                    pend_set = 1'b1;
                end
            end
            default: begin
                if (flush) begin
                    pc_stall = 1'b0;
                    next_pc  = flush_target;
                    kill     = 1'b1;
                end
            end
        endcase
        if (rst) begin
            pc_stall = 1'b1;
            next_pc  = pc;
            imem_req = 1'b0;
            fill     = 1'b0;
            kill     = 1'b0;
            pend_set = 1'b0;
            pend_clr = 1'b0;
        end
    end

    // Instruction buffer, pending redirect, timeout counter and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst        <= NOP_INST;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
            fetch_err   <= 1'b0;
            pend        <= 1'b0;
            pend_target <= '0;
            tcount      <= '0;
        end else begin
            if (kill) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end else if (fill) begin
                inst       <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end else if (inst_valid && !id_stall) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end

            if (pend_clr || timeout_hit) begin
                pend <= 1'b0;
            end else if (pend_set) begin
                pend <= 1'b1;
            end
            if (pend_set) begin
                pend_target <= flush_target;
            end

            if (state == FETCH && !imem_ack && !flush && !timeout_hit) begin
                tcount <= tcount + TW'(1);
            end else begin
                tcount <= '0;
            end

            if (exc_valid) begin
                fetch_err <= 1'b0;
            end else if (timeout_hit) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_elbeth_fetch_sequencer.sv
// Bench for elbeth_fetch_sequencer: directed scenarios plus random traffic, with the
// delivered instruction stream checked against an address-stream reference model.
module tb_elbeth_fetch_sequencer;
    localparam logic [31:0] EXC_VEC = 32'h0000_0010;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc_valid = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        fetch_err;

    elbeth_fetch_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc), .pc_stall(pc_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .id_stall(id_stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .exc_valid(exc_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_valid(inst_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Environment PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= '0;
        else if (!pc_stall) pc <= next_pc;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int consumed = 0;

    // A stream segment: from cycle 'tag' on, decode must see addresses addr, addr+4, ...
    typedef struct {
        int          tag;
        logic [31:0] addr;
    } seg_t;
    seg_t        seg_q[$];
    logic [31:0] cur = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive one cycle of inputs; a flush starts a new expected stream segment.
    task automatic drive(input bit ack, input bit stall, input bit exc, input bit redir,
                         input logic [31:0] tgt);
        imem_ack       = ack & imem_req;
        imem_rdata     = imem_ack ? mem_word(pc) : 32'hDEAD_BEEF;
        id_stall       = stall;
        exc_valid      = exc;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (exc) seg_q.push_back('{cyc, EXC_VEC});
        else if (redir) seg_q.push_back('{cyc, tgt});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, '0);
        seg_q.delete();
        seg_q.push_back('{cyc, 32'h0});
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every consumed instruction must be the next one of the current stream.
    always @(negedge clk) begin
        seg_t s;
        if (!rst) begin
            while (seg_q.size() > 0 && seg_q[0].tag < cyc) begin
                s = seg_q.pop_front();
                cur = s.addr;
            end
            if (inst_valid && !id_stall) begin
                check("stream_pc", inst_pc, cur);
                check("stream_word", inst, mem_word(cur));
                cur = cur + 32'd4;
                consumed++;
            end else if (!inst_valid) begin
                check("empty_nop", inst, NOP);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p0;
        logic [31:0] i0;
        logic [31:0] tgt;
        int n;
        int r;
        int ack_pct;

        do_reset();
        check("rst_req", 32'(imem_req), 0);
        check("rst_stall", 32'(pc_stall), 1);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_err", 32'(fetch_err), 0);

        // Back-to-back acks: one instruction per cycle
        drive(1, 0, 0, 0, '0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("b2b_valid", 32'(inst_valid), (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) check("b2b_pc", inst_pc, 32'((i - 2) * 4));
            drive(1, 0, 0, 0, '0);
        end

        // Decode stall holds PC and buffer, drops request
        drive(1, 1, 0, 0, '0);
        p0 = pc;
        i0 = inst_pc;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1, 1, 0, 0, '0);
        end
        check("stall_req", 32'(imem_req), 0);
        check("stall_valid", 32'(inst_valid), 1);
        check("stall_inst_pc", inst_pc, i0);
        check("stall_pc", pc, p0);
        drive(1, 0, 0, 0, '0);
        tick();
        check("resume_req", 32'(imem_req), 1);
        check("resume_addr", imem_addr, p0);

        // Redirect mid-fetch, ack two cycles later
        drive(0, 0, 0, 1, 32'h100);
        tick();
        drive(0, 0, 0, 0, '0);
        tick();
        check("pend_valid", 32'(inst_valid), 0);
        drive(1, 0, 0, 0, '0);
        #1;
        check("pend_stall", 32'(pc_stall), 0);
        check("pend_next", next_pc, 32'h100);
        tick();
        check("pend_drop", 32'(inst_valid), 0);
        check("pend_addr", imem_addr, 32'h100);

        // Exception beats redirect
        drive(1, 0, 0, 0, '0);
        tick();
        drive(1, 1, 0, 0, '0);
        tick();
        drive(1, 1, 1, 1, 32'h200);
        #1;
        check("exc_next", next_pc, EXC_VEC);
        check("exc_stall", 32'(pc_stall), 0);
        tick();
        check("exc_valid_clr", 32'(inst_valid), 0);
        check("exc_pc", pc, EXC_VEC);

        // PC wrap
        drive(1, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, '0);
        #1;
        check("wrap_next", next_pc, 32'h0);
        tick();
        check("wrap_pc0", pc, 32'h0);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, '0);
        check("pre_rst_req", 32'(imem_req), 1);

        // Async reset mid-request; a late ack must be ignored
        rst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 0);
        check("arst_valid", 32'(inst_valid), 0);
        seg_q.delete();
        seg_q.push_back('{cyc, 32'h0});
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        rst = 1'b0;
        tick();
        check("late_ack_pc", pc, 32'h0);
        check("late_ack_valid", 32'(inst_valid), 0);

        // Timeout and exception recovery
        do_reset();
        drive(0, 0, 0, 0, '0);
        n = 0;
        while (!imem_req && n < 4) begin
            tick();
            n++;
        end
        check("to_req_up", 32'(imem_req), 1);
        n = 0;
        while (imem_req && n < 300) begin
            drive(0, 0, 0, 0, '0);
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'd255);
        check("to_err", 32'(fetch_err), 1);
        check("to_req", 32'(imem_req), 0);
        drive(0, 0, 1, 0, '0);
        #1;
        check("to_exc_next", next_pc, EXC_VEC);
        tick();
        check("to_err_clr", 32'(fetch_err), 0);
        check("to_resume_req", 32'(imem_req), 1);
        check("to_resume_addr", imem_addr, EXC_VEC);

        // Random traffic at three memory speeds
        for (int pass = 0; pass < 3; pass++) begin
            ack_pct = (pass == 0) ? 100 : (pass == 1) ? 60 : 20;
            for (int i = 0; i < 2000; i++) begin
                r = int'($urandom_range(0, 99));
                tgt = ($urandom_range(0, 3) == 0)
                      ? 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2)
                      : 32'($urandom_range(0, 1023)) << 2;
                drive(int'($urandom_range(0, 99)) < ack_pct,
                      int'($urandom_range(0, 99)) < 30,
                      r < 2, r >= 2 && r < 7, tgt);
                tick();
            end
        end
        drive(0, 0, 0, 0, '0);
        tick();
        total++;
        if (consumed < 500) begin
            bad++;
            $display("FAIL progress: got %0d consumed want at least 500", consumed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
